jtpopeye_bck_scan: RTL and testbench

- Video-side reader for the background RAM that the CPU write path fills with packed nibbles.
- Applies X/Y scroll to the raster position, fetches RAM bytes, selects a nibble and produces the 5-bit background colour BAKC with matched blanking.
- Arbitrates the RAM port against CPU accesses.
- Sits between the video timing generator and the colour mixer.

---
 rtl/jtpopeye_bck_scan.sv | 166 ++++++++++++++++
 tb/tb_jtpopeye_bck_scan.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_bck_scan.sv
// Background scan reader.
// Applies X/Y scroll to the raster position, fetches packed-nibble bytes from the
// shared background RAM, selects a nibble and emits the 5-bit colour {bank, nibble}
// together with blanking delayed to match. The RAM port is shared with the CPU,
// and the CPU always wins.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   pxl_cen_i           pixel clock enable (spacing >= 3 clk)
//   h_i, v_i            raster counters
//   lhbl_i, lvbl_i      active-low blanking inputs
//   scr_we_i, scr_sel_i scroll register write strobe and select
//   dd_i                CPU data for scroll writes
//   cpu_cs_i            CPU owns the RAM port this clk
//   cpu_addr_i          CPU RAM address
//   ram_addr_o          address to the shared RAM
//   ram_dout_i          RAM read data, valid one clk after address
//   bakc_o              background colour {bank, nibble}
//   lhbl_dly_o          lhbl_i aligned with bakc_o
//   lvbl_dly_o          lvbl_i aligned with bakc_o
module jtpopeye_bck_scan #(
  parameter int unsigned AW  = 12,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen_i,
  input  logic [8:0]    h_i,
  input  logic [7:0]    v_i,
  input  logic          lhbl_i,
  input  logic          lvbl_i,
  input  logic          scr_we_i,
  input  logic [1:0]    scr_sel_i,
  input  logic [7:0]    dd_i,
  input  logic          cpu_cs_i,
  input  logic [AW-1:0] cpu_addr_i,
  output logic [AW-1:0] ram_addr_o,
  input  logic [7:0]    ram_dout_i,
  output logic [4:0]    bakc_o,
  output logic          lhbl_dly_o,
  output logic          lvbl_dly_o
);

  // The pipeline below is hard-wired to two pixel stages.
  if (LAT != 2) begin : g_bad_lat
    $error("jtpopeye_bck_scan: LAT must be 2");
  end

  logic [8:0]    scroll_x_q, scroll_x_d;
  logic [7:0]    scroll_y_q, scroll_y_d;
  logic          bank_q, bank_d;

  logic [AW-1:0] scan_addr_q, scan_addr_d;
  logic          nib_sel0_q, nib_sel0_d;
  logic          lhbl0_q, lhbl0_d;
  logic          lvbl0_q, lvbl0_d;
  logic          req0_q, req0_d;
  logic          cap_q, cap_d;      // ram_dout holds our fetch this clk
  logic          rd_ok_q, rd_ok_d;  // fetch was not stolen by the CPU
  logic [7:0]    byte1_q, byte1_d;

  logic [4:0]    bakc_q, bakc_d;
  logic          lhbl_dly_q, lhbl_dly_d;
  logic          lvbl_dly_q, lvbl_dly_d;

  logic [8:0]    hs;
  logic [7:0]    vs;
  logic          blank;
  logic [3:0]    nibble;

  assign hs = h_i + scroll_x_q;
  assign vs = v_i + scroll_y_q;

  assign blank  = !lhbl0_q || !lvbl0_q;
  assign nibble = nib_sel0_q ? byte1_q[7:4] : byte1_q[3:0];

  assign ram_addr_o = cpu_cs_i ? cpu_addr_i : scan_addr_q;

  always_comb begin
    scroll_x_d  = scroll_x_q;
    scroll_y_d  = scroll_y_q;
    bank_d      = bank_q;
    scan_addr_d = scan_addr_q;
    nib_sel0_d  = nib_sel0_q;
    lhbl0_d     = lhbl0_q;
    lvbl0_d     = lvbl0_q;
    req0_d      = 1'b0;
    cap_d       = req0_q;
    rd_ok_d     = rd_ok_q;
    byte1_d     = byte1_q;
    bakc_d      = bakc_q;
    lhbl_dly_d  = lhbl_dly_q;
    lvbl_dly_d  = lvbl_dly_q;

    if (scr_we_i) begin
      case (scr_sel_i)
        2'd0:    scroll_x_d[7:0] = dd_i;
        2'd1:    {bank_d, scroll_x_d[8]} = dd_i[1:0];
        2'd2:    scroll_y_d = dd_i;
        default: ;
      endcase
    end

    // Clk after stage 0: the scan address is on the port unless the CPU took it.
    if (req0_q) begin
      rd_ok_d = !cpu_cs_i;
    end

    // A stolen fetch leaves byte1 untouched so the previous pixel repeats.
    if (cap_q && rd_ok_q) begin
      byte1_d = ram_dout_i;
    end

    if (pxl_cen_i) begin
      // Stage 0: sample position and blanking, launch the fetch.
      scan_addr_d = AW'({vs[7:3], hs[8:2]});
      nib_sel0_d  = vs[2];
      lhbl0_d     = lhbl_i;
      lvbl0_d     = lvbl_i;
      req0_d      = 1'b1;
      // Stage 1: colour for the pixel sampled at the previous pxl_cen.
      bakc_d      = blank ? 5'd0 : {bank_q, nibble};
      lhbl_dly_d  = lhbl0_q;
      lvbl_dly_d  = lvbl0_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_x_q  <= '0;
      scroll_y_q  <= '0;
      bank_q      <= 1'b0;
      scan_addr_q <= '0;
      nib_sel0_q  <= 1'b0;
      lhbl0_q     <= 1'b0;
      lvbl0_q     <= 1'b0;
      req0_q      <= 1'b0;
      cap_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
      byte1_q     <= '0;
      bakc_q      <= '0;
      lhbl_dly_q  <= 1'b0;
      lvbl_dly_q  <= 1'b0;
    end else begin
      scroll_x_q  <= scroll_x_d;
      scroll_y_q  <= scroll_y_d;
      bank_q      <= bank_d;
      scan_addr_q <= scan_addr_d;
      nib_sel0_q  <= nib_sel0_d;
      lhbl0_q     <= lhbl0_d;
      lvbl0_q     <= lvbl0_d;
      req0_q      <= req0_d;
      cap_q       <= cap_d;
      rd_ok_q     <= rd_ok_d;
      byte1_q     <= byte1_d;
      bakc_q      <= bakc_d;
      lhbl_dly_q  <= lhbl_dly_d;
      lvbl_dly_q  <= lvbl_dly_d;
    end
  end

  assign bakc_o     = bakc_q;
  assign lhbl_dly_o = lhbl_dly_q;
  assign lvbl_dly_o = lvbl_dly_q;

endmodule

// File: tb/tb_jtpopeye_bck_scan.sv
// Bench for jtpopeye_bck_scan: directed cases followed by random pixels, checked
// against a pixel-level model (scroll arithmetic, a RAM array, a held byte).
module tb_jtpopeye_bck_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen_i = 1'b0;
  logic [8:0]  h_i = '0;
  logic [7:0]  v_i = '0;
  logic        lhbl_i = 1'b1;
  logic        lvbl_i = 1'b1;
  logic        scr_we_i = 1'b0;
  logic [1:0]  scr_sel_i = '0;
  logic [7:0]  dd_i = '0;
  logic        cpu_cs_i = 1'b0;
  logic [11:0] cpu_addr_i = '0;
  logic [11:0] ram_addr_o;
  logic [7:0]  ram_dout_i = '0;
  logic [4:0]  bakc_o;
  logic        lhbl_dly_o;
  logic        lvbl_dly_o;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [0:4095];

  // Model state
  int         m_sx, m_sy;
  logic       m_bank;
  logic [7:0] m_byte;
  logic       m_lh, m_lv, m_nib;

  jtpopeye_bck_scan #(.AW(12), .LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pxl_cen_i  (pxl_cen_i),
    .h_i        (h_i),
    .v_i        (v_i),
    .lhbl_i     (lhbl_i),
    .lvbl_i     (lvbl_i),
    .scr_we_i   (scr_we_i),
    .scr_sel_i  (scr_sel_i),
    .dd_i       (dd_i),
    .cpu_cs_i   (cpu_cs_i),
    .cpu_addr_i (cpu_addr_i),
    .ram_addr_o (ram_addr_o),
    .ram_dout_i (ram_dout_i),
    .bakc_o     (bakc_o),
    .lhbl_dly_o (lhbl_dly_o),
    .lvbl_dly_o (lvbl_dly_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM
  always @(posedge clk) ram_dout_i <= mem[ram_addr_o];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_bank = 1'b0; m_byte = 8'h00;
    m_lh = 1'b0; m_lv = 1'b0; m_nib = 1'b0;
  endtask

  task automatic scr_write(input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    scr_we_i = 1'b1; scr_sel_i = sel; dd_i = d;
    @(posedge clk);
    #1 scr_we_i = 1'b0;
    case (sel)
      2'd0: m_sx = (m_sx & 256) | int'(d);
      2'd1: begin m_bank = d[1]; m_sx = (m_sx & 255) | (d[0] ? 256 : 0); end
      2'd2: m_sy = int'(d);
      default: ;
    endcase
  endtask

  // One pixel: sample at pxl_cen, check the previous pixel's output and the fetch
  // address, optionally let the CPU steal the fetch clk.
  task automatic pixel(input logic [8:0] h, input logic [7:0] v, input logic lh,
                       input logic lv, input logic cs);
    int hs, vs, a;
    logic [4:0] e;
    @(negedge clk);
    h_i = h; v_i = v; lhbl_i = lh; lvbl_i = lv; pxl_cen_i = 1'b1; cpu_cs_i = 1'b0;
    @(posedge clk);
    #1 pxl_cen_i = 1'b0;
    e = (!m_lh || !m_lv) ? 5'd0 : {m_bank, m_nib ? m_byte[7:4] : m_byte[3:0]};
    chk("bakc", 32'(bakc_o), 32'(e));
    chk("lhbl_dly", 32'(lhbl_dly_o), 32'(m_lh));
    chk("lvbl_dly", 32'(lvbl_dly_o), 32'(m_lv));
    hs = (int'(h) + m_sx) % 512;
    vs = (int'(v) + m_sy) % 256;
    a  = (vs / 8) * 128 + hs / 4;
    chk("scan_addr", 32'(ram_addr_o), 32'(a));
    if (cs) begin
      cpu_cs_i = 1'b1;
      #1 chk("cpu_addr", 32'(ram_addr_o), 32'(cpu_addr_i));
    end
    @(posedge clk);
    #1 cpu_cs_i = 1'b0;
    if (!cs) m_byte = mem[a];
    m_lh = lh; m_lv = lv; m_nib = ((vs / 4) % 2) == 1;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    mem[1] = 8'h37;
    mem[2] = 8'h9C;
    model_reset();

    // Reset held over clock edges
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bakc", 32'(bakc_o), 32'd0);
    chk("rst_lhbl_dly", 32'(lhbl_dly_o), 32'd0);
    chk("rst_lvbl_dly", 32'(lvbl_dly_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic nibble select and bank
    pixel(9'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    pixel(9'd0, 8'd4, 1'b1, 1'b1, 1'b0);
    chk("lo_nibble", 32'(bakc_o), 32'h05);
    pixel(9'd0, 8'd4, 1'b1, 1'b1, 1'b0);
    chk("hi_nibble", 32'(bakc_o), 32'h0A);
    scr_write(2'd1, 8'h02);
    pixel(9'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    chk("bank_nibble", 32'(bakc_o), 32'h1A);
    scr_write(2'd1, 8'h00);

    // Scroll wrap
    scr_write(2'd0, 8'hFF);
    scr_write(2'd1, 8'h01);
    pixel(9'd1, 8'd0, 1'b1, 1'b1, 1'b0);
    scr_write(2'd0, 8'h00);
    scr_write(2'd1, 8'h00);
    scr_write(2'd2, 8'hFF);
    pixel(9'd0, 8'd1, 1'b1, 1'b1, 1'b0);
    scr_write(2'd3, 8'h55);
    scr_write(2'd2, 8'h00);

    // One blanked pixel
    pixel(9'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    pixel(9'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    chk("hblank_bakc", 32'(bakc_o), 32'h00);
    chk("hblank_dly", 32'(lhbl_dly_o), 32'd0);
    pixel(9'd4, 8'd0, 1'b1, 1'b1, 1'b0);
    chk("after_blank", 32'(bakc_o), 32'h05);

    // CPU steals the fetch: previous pixel repeats
    cpu_addr_i = 12'hABC;
    pixel(9'd8, 8'd0, 1'b1, 1'b1, 1'b1);
    chk("pre_steal", 32'(bakc_o), 32'h07);
    pixel(9'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    chk("stale_repeat", 32'(bakc_o), 32'h07);

    // Random pixels with occasional scroll writes and CPU steals
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) scr_write(2'($urandom), 8'($urandom));
      cpu_addr_i = 12'($urandom);
      pixel(9'($urandom), 8'($urandom), $urandom_range(0, 7) != 0,
            $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
    end

    // Mid-line reset with live output and nonzero scroll
    scr_write(2'd0, 8'h00);
    scr_write(2'd1, 8'h00);
    scr_write(2'd2, 8'h00);
    pixel(9'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    pixel(9'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    chk("pre_reset", 32'(bakc_o), 32'h05);
    scr_write(2'd0, 8'h44);
    scr_write(2'd2, 8'h28);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bakc", 32'(bakc_o), 32'd0);
    chk("midrst_lhbl", 32'(lhbl_dly_o), 32'd0);
    chk("midrst_lvbl", 32'(lvbl_dly_o), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pixel(9'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    pixel(9'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    chk("post_reset", 32'(bakc_o), 32'h05);
    for (int i = 0; i < 20; i++) begin
      pixel(9'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
